// File: rtl/icache_refill_responder_if.sv
// Instruction-cache refill bus: one command channel (cache -> memory) and one
// response beat channel (memory -> cache, no back-pressure).
interface icache_refill_responder_if;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready;
  logic [31:0] mem_cmd_payload_address;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_payload_data;
  logic        mem_rsp_payload_error;

  modport master (
    output mem_cmd_valid, mem_cmd_payload_address,
    input  mem_cmd_ready, mem_rsp_valid, mem_rsp_payload_data, mem_rsp_payload_error
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_payload_address,
    output mem_cmd_ready, mem_rsp_valid, mem_rsp_payload_data, mem_rsp_payload_error
  );
endinterface

// File: rtl/icache_refill_responder.sv
// Line-refill responder: accepts one refill command, waits LATENCY cycles, then
// streams BEATS words from an internal preloadable store (or error beats).
module icache_refill_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          BEATS       = 8,
  parameter int          LATENCY     = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  icache_refill_responder_if.slave       bus,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data,
  output logic                           busy,
  output logic [15:0]                    lines_served,
  output logic [15:0]                    error_lines
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int BW = $clog2(BEATS);
  localparam logic [31:0] OFF_MASK = 32'(BEATS * 4 - 1);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   word_base_q, word_base_d;
  logic            err_q, err_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [15:0]     lines_q, lines_d;
  logic [15:0]     errl_q, errl_d;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     cmd_line;
  logic [31:0]     cmd_off;
  logic            cmd_err;
  logic [AW-1:0]   rd_idx;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // 33-bit range check so lines near 4 GiB never alias back into the store
  assign cmd_line = bus.mem_cmd_payload_address & ~OFF_MASK;
  assign cmd_off  = cmd_line - BASE_ADDR;
  assign cmd_err  = ({1'b0, cmd_line} < {1'b0, BASE_ADDR}) || ({1'b0, cmd_line} >= LIMIT);

  // The beat register is loaded on the edge that enters/continues BURST, so the
  // read index is formed from next-state values.
  assign rd_idx = word_base_d + AW'(beat_cnt_d);

  always_comb begin
    state_d     = state_q;
    word_base_d = word_base_q;
    err_d       = err_q;
    beat_cnt_d  = beat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    lines_d     = lines_q;
    errl_d      = errl_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_cmd_valid) begin
          word_base_d = AW'(cmd_off >> 2);
          err_d       = cmd_err;
          beat_cnt_d  = '0;
          wait_cnt_d  = 4'(LATENCY);
          if (LATENCY == 0) state_d = BURST;
          else              state_d = WAIT;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          state_d    = BURST;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (beat_cnt_q == BW'(BEATS - 1)) begin
          state_d = IDLE;
          lines_d = sat_inc(lines_q);
          if (err_q) errl_d = sat_inc(errl_q);
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == BURST);
    if (rsp_valid_d) begin
      rsp_data_d = err_d ? 32'h0 : mem[rd_idx];
      rsp_err_d  = err_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      word_base_q <= '0;
      err_q       <= 1'b0;
      beat_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      lines_q     <= '0;
      errl_q      <= '0;
    end else begin
      state_q     <= state_d;
      word_base_q <= word_base_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      lines_q     <= lines_d;
      errl_q      <= errl_d;
    end
  end

  // Store is not reset; a same-cycle read sees the word before this write
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign bus.mem_cmd_ready         = (state_q == IDLE);
  assign bus.mem_rsp_valid         = rsp_valid_q;
  assign bus.mem_rsp_payload_data  = rsp_data_q;
  assign bus.mem_rsp_payload_error = rsp_err_q;
  assign busy                      = (state_q != IDLE);
  assign lines_served              = lines_q;
  assign error_lines               = errl_q;

endmodule

// File: tb/tb_icache_refill_responder.sv
// Bench for icache_refill_responder: a LATENCY=2 instance for most scenarios and
// a LATENCY=0 instance for back-to-back command streaming.
module tb_icache_refill_responder;

  localparam int     L     = 2;
  localparam int     B     = 8;
  localparam int     DEPTH = 1024;
  localparam int     NC    = L + B + 1;
  localparam longint BASE  = 0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        busy_a, busy_b;
  logic [15:0] ls_a, el_a, ls_b, el_b;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] e_data [0:B-1];
  logic        e_err;
  int          exp_lines = 0;
  int          exp_errl = 0;

  logic        o_ready0;
  logic        o_valid [1:NC];
  logic        o_ready [1:NC];
  logic        o_busy  [1:NC];
  logic        o_err   [1:NC];
  logic [31:0] o_data  [1:NC];
  logic [15:0] o_ls    [1:NC];
  logic [15:0] o_el    [1:NC];

  icache_refill_responder_if bus_a();
  icache_refill_responder_if bus_b();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache_refill_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(DEPTH), .BEATS(B), .LATENCY(L)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy_a), .lines_served(ls_a), .error_lines(el_a)
  );

  icache_refill_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(DEPTH), .BEATS(B), .LATENCY(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy_b), .lines_served(ls_b), .error_lines(el_b)
  );

  // Reference: a line is its aligned base; out of range -> zero data with error
  task automatic expect_line(input logic [31:0] addr);
    longint lb;
    lb    = longint'(addr) & ~longint'(B * 4 - 1);
    e_err = (lb < BASE) || (lb >= BASE + 4 * DEPTH);
    for (int k = 0; k < B; k++)
      e_data[k] = e_err ? 32'h0 : ref_mem[int'((lb - BASE) / 4) + k];
  endtask

  // Issues one command on bus_a at the current negedge and records every cycle
  // up to the one where ready returns; optionally writes one word mid-burst.
  task automatic capture(input logic [31:0] addr, input int wr_beat, input logic [31:0] wr_data);
    int w;
    o_ready0 = bus_a.mem_cmd_ready;
    bus_a.mem_cmd_valid = 1'b1;
    bus_a.mem_cmd_payload_address = addr;
    @(negedge clk);
    bus_a.mem_cmd_valid = 1'b0;
    bus_a.mem_cmd_payload_address = $urandom;
    for (int c = 1; c <= NC; c++) begin
      load_en    = 1'b0;
      o_valid[c] = bus_a.mem_rsp_valid;
      o_ready[c] = bus_a.mem_cmd_ready;
      o_busy[c]  = busy_a;
      o_err[c]   = bus_a.mem_rsp_payload_error;
      o_data[c]  = bus_a.mem_rsp_payload_data;
      o_ls[c]    = ls_a;
      o_el[c]    = el_a;
      if (wr_beat >= 0 && c == L + 1 + wr_beat) begin
        w = int'(((longint'(addr) & ~longint'(B * 4 - 1)) - BASE) / 4) + wr_beat;
        load_en   = 1'b1;
        load_addr = 10'(w);
        load_data = wr_data;
        ref_mem[w] = wr_data;
      end
      if (c < NC) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++; if (bus_a.mem_cmd_ready !== 1'b1 || busy_a !== 1'b0) begin errors++;
      $display("FAIL reset_ready_a: ready=%b busy=%b expected 1/0", bus_a.mem_cmd_ready, busy_a); end
    checks++; if (bus_a.mem_rsp_valid !== 1'b0 || bus_a.mem_rsp_payload_data !== 32'h0 || bus_a.mem_rsp_payload_error !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_a: valid=%b data=%h err=%b expected 0/0/0", bus_a.mem_rsp_valid, bus_a.mem_rsp_payload_data, bus_a.mem_rsp_payload_error); end
    checks++; if (ls_a !== 16'h0 || el_a !== 16'h0) begin errors++;
      $display("FAIL reset_cnt_a: lines=%h errl=%h expected 0/0", ls_a, el_a); end
    checks++; if (bus_b.mem_cmd_ready !== 1'b1 || busy_b !== 1'b0 || bus_b.mem_rsp_valid !== 1'b0 || bus_b.mem_rsp_payload_data !== 32'h0) begin errors++;
      $display("FAIL reset_b: ready=%b busy=%b valid=%b data=%h expected 1/0/0/0", bus_b.mem_cmd_ready, busy_b, bus_b.mem_rsp_valid, bus_b.mem_rsp_payload_data); end
    checks++; if (ls_b !== 16'h0 || el_b !== 16'h0 || bus_b.mem_rsp_payload_error !== 1'b0) begin errors++;
      $display("FAIL reset_cnt_b: lines=%h errl=%h err=%b expected 0/0/0", ls_b, el_b, bus_b.mem_rsp_payload_error); end
  endtask

  task automatic preload();
    for (int i = 0; i < DEPTH; i++) begin
      load_en   = 1'b1;
      load_addr = 10'(i);
      load_data = (i < 16) ? 32'hA000_0000 + 32'(i) : $urandom;
      ref_mem[i] = load_data;
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic test_abort();
    expect_line(32'h40);
    bus_a.mem_cmd_valid = 1'b1;
    bus_a.mem_cmd_payload_address = 32'h40;
    @(negedge clk);
    bus_a.mem_cmd_valid = 1'b0;
    repeat (L + 4) @(negedge clk);
    checks++; if (bus_a.mem_rsp_valid !== 1'b1 || bus_a.mem_rsp_payload_data !== e_data[4]) begin errors++;
      $display("FAIL abort_beat4: valid=%b data=%h expected 1/%h", bus_a.mem_rsp_valid, bus_a.mem_rsp_payload_data, e_data[4]); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus_a.mem_rsp_valid !== 1'b0) begin errors++;
      $display("FAIL abort_valid_drop: valid=%b expected 0", bus_a.mem_rsp_valid); end
    checks++; if (bus_a.mem_cmd_ready !== 1'b1 || busy_a !== 1'b0) begin errors++;
      $display("FAIL abort_ready: ready=%b busy=%b expected 1/0", bus_a.mem_cmd_ready, busy_a); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_lines = 0; exp_errl = 0;
    @(negedge clk);
    checks++; if (bus_a.mem_cmd_ready !== 1'b1 || ls_a !== 16'(exp_lines) || el_a !== 16'(exp_errl)) begin errors++;
      $display("FAIL abort_after: ready=%b lines=%0d errl=%0d expected 1/%0d/%0d", bus_a.mem_cmd_ready, ls_a, el_a, exp_lines, exp_errl); end
    capture(32'h40, -1, 32'h0);
    exp_lines++;
    for (int k = 0; k < B; k++) begin
      checks++; if (o_valid[L+1+k] !== 1'b1 || o_data[L+1+k] !== e_data[k] || o_err[L+1+k] !== 1'b0) begin errors++;
        $display("FAIL abort_retry_beat%0d: valid=%b data=%h err=%b expected 1/%h/0", k, o_valid[L+1+k], o_data[L+1+k], o_err[L+1+k], e_data[k]); end
    end
    checks++; if (o_ls[NC] !== 16'(exp_lines)) begin errors++;
      $display("FAIL abort_retry_lines: got %0d expected %0d", o_ls[NC], exp_lines); end
  endtask

  task automatic test_basic();
    logic ev;
    capture(32'h20, -1, 32'h0);
    checks++; if (o_ready0 !== 1'b1) begin errors++;
      $display("FAIL basic_ready_before: got %b expected 1", o_ready0); end
    for (int c = 1; c <= NC; c++) begin
      ev = (c >= L + 1) && (c <= L + B);
      checks++; if (o_valid[c] !== ev || o_ready[c] !== (c == NC) || o_busy[c] !== (c != NC)) begin errors++;
        $display("FAIL basic_timing_c%0d: valid=%b ready=%b busy=%b expected %b/%b/%b", c, o_valid[c], o_ready[c], o_busy[c], ev, c == NC, c != NC); end
      if (ev) begin
        checks++; if (o_data[c] !== 32'hA000_0008 + 32'(c - L - 1) || o_err[c] !== 1'b0) begin errors++;
          $display("FAIL basic_beat_c%0d: data=%h err=%b expected %h/0", c, o_data[c], o_err[c], 32'hA000_0008 + 32'(c - L - 1)); end
      end
    end
    checks++; if (o_data[NC] !== 32'hA000_000F || o_err[NC] !== 1'b0) begin errors++;
      $display("FAIL basic_hold: data=%h err=%b expected a000000f/0", o_data[NC], o_err[NC]); end
    checks++; if (o_ls[NC-1] !== 16'(exp_lines)) begin errors++;
      $display("FAIL basic_lines_early: got %0d expected %0d", o_ls[NC-1], exp_lines); end
    exp_lines++;
    checks++; if (o_ls[NC] !== 16'(exp_lines) || o_el[NC] !== 16'(exp_errl)) begin errors++;
      $display("FAIL basic_lines: lines=%0d errl=%0d expected %0d/%0d", o_ls[NC], o_el[NC], exp_lines, exp_errl); end
  endtask

  task automatic test_unaligned();
    capture(32'h2C, -1, 32'h0);
    exp_lines++;
    for (int k = 0; k < B; k++) begin
      checks++; if (o_valid[L+1+k] !== 1'b1 || o_data[L+1+k] !== 32'hA000_0008 + 32'(k) || o_err[L+1+k] !== 1'b0) begin errors++;
        $display("FAIL unaligned_beat%0d: valid=%b data=%h err=%b expected 1/%h/0", k, o_valid[L+1+k], o_data[L+1+k], o_err[L+1+k], 32'hA000_0008 + 32'(k)); end
    end
    checks++; if (o_ls[NC] !== 16'(exp_lines)) begin errors++;
      $display("FAIL unaligned_lines: got %0d expected %0d", o_ls[NC], exp_lines); end
  endtask

  task automatic test_oor();
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_1000;
    addrs[1] = 32'hFFFF_FFE4;
    for (int a = 0; a < 2; a++) begin
      capture(addrs[a], -1, 32'h0);
      exp_lines++; exp_errl++;
      for (int k = 0; k < B; k++) begin
        checks++; if (o_valid[L+1+k] !== 1'b1 || o_data[L+1+k] !== 32'h0 || o_err[L+1+k] !== 1'b1) begin errors++;
          $display("FAIL oor%0d_beat%0d: valid=%b data=%h err=%b expected 1/0/1", a, k, o_valid[L+1+k], o_data[L+1+k], o_err[L+1+k]); end
      end
      checks++; if (o_ls[NC] !== 16'(exp_lines) || o_el[NC] !== 16'(exp_errl)) begin errors++;
        $display("FAIL oor%0d_counts: lines=%0d errl=%0d expected %0d/%0d", a, o_ls[NC], o_el[NC], exp_lines, exp_errl); end
    end
  endtask

  task automatic test_top_of_range();
    expect_line(32'h0000_0FE0);
    capture(32'h0000_0FE0, -1, 32'h0);
    exp_lines++;
    for (int k = 0; k < B; k++) begin
      checks++; if (o_valid[L+1+k] !== 1'b1 || o_data[L+1+k] !== ref_mem[1016+k] || o_err[L+1+k] !== 1'b0) begin errors++;
        $display("FAIL top_beat%0d: valid=%b data=%h err=%b expected 1/%h/0", k, o_valid[L+1+k], o_data[L+1+k], o_err[L+1+k], ref_mem[1016+k]); end
    end
    checks++; if (o_ls[NC] !== 16'(exp_lines) || o_el[NC] !== 16'(exp_errl)) begin errors++;
      $display("FAIL top_counts: lines=%0d errl=%0d expected %0d/%0d", o_ls[NC], o_el[NC], exp_lines, exp_errl); end
  endtask

  task automatic test_rbw();
    logic [31:0] old3;
    old3 = ref_mem[27];
    capture(32'h60, 3, 32'hDEAD_BEEF);
    exp_lines++;
    checks++; if (o_data[L+4] !== old3 || o_valid[L+4] !== 1'b1) begin errors++;
      $display("FAIL rbw_first: data=%h valid=%b expected %h/1", o_data[L+4], o_valid[L+4], old3); end
    expect_line(32'h60);
    capture(32'h60, -1, 32'h0);
    exp_lines++;
    for (int k = 0; k < B; k++) begin
      checks++; if (o_data[L+1+k] !== e_data[k] || o_valid[L+1+k] !== 1'b1) begin errors++;
        $display("FAIL rbw_second_beat%0d: data=%h valid=%b expected %h/1", k, o_data[L+1+k], o_valid[L+1+k], e_data[k]); end
    end
    checks++; if (o_data[L+4] !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL rbw_new_word: got %h expected deadbeef", o_data[L+4]); end
  endtask

  task automatic test_lat0_back_to_back();
    logic [31:0] a [2];
    logic [31:0] exp_d [16];
    int          hs [2];
    int          nhs;
    logic [31:0] got_d [$];
    int          got_c [$];
    logic        err_seen;
    int          ec;
    a[0] = 32'h100; a[1] = 32'h240;
    expect_line(a[0]); for (int k = 0; k < B; k++) exp_d[k] = e_data[k];
    expect_line(a[1]); for (int k = 0; k < B; k++) exp_d[B+k] = e_data[k];
    nhs = 0; hs[0] = 0; hs[1] = 0; err_seen = 1'b0;
    bus_b.mem_cmd_valid = 1'b1;
    bus_b.mem_cmd_payload_address = a[0];
    for (int n = 0; n < 30; n++) begin
      if (n > 0) begin
        @(negedge clk);
        if (nhs == 1) bus_b.mem_cmd_payload_address = a[1];
        else if (nhs == 2) bus_b.mem_cmd_valid = 1'b0;
      end
      if (bus_b.mem_rsp_valid === 1'b1) begin
        got_d.push_back(bus_b.mem_rsp_payload_data);
        got_c.push_back(cyc);
        err_seen = err_seen | bus_b.mem_rsp_payload_error;
      end
      if (bus_b.mem_cmd_ready === 1'b1 && bus_b.mem_cmd_valid === 1'b1 && nhs < 2) begin
        hs[nhs] = cyc;
        nhs++;
      end
    end
    bus_b.mem_cmd_valid = 1'b0;
    checks++; if (nhs != 2 || hs[1] - hs[0] != B + 1) begin errors++;
      $display("FAIL lat0_spacing: handshakes=%0d spacing=%0d expected 2/%0d", nhs, hs[1] - hs[0], B + 1); end
    checks++; if (got_d.size() != 2 * B) begin errors++;
      $display("FAIL lat0_beat_count: got %0d expected %0d", got_d.size(), 2 * B); end
    for (int i = 0; i < got_d.size() && i < 2 * B; i++) begin
      ec = (i < B) ? hs[0] + 1 + i : hs[1] + 1 + (i - B);
      checks++; if (got_d[i] !== exp_d[i] || got_c[i] != ec) begin errors++;
        $display("FAIL lat0_beat%0d: data=%h cycle=%0d expected %h/%0d", i, got_d[i], got_c[i], exp_d[i], ec); end
    end
    checks++; if (err_seen !== 1'b0 || ls_b !== 16'd2) begin errors++;
      $display("FAIL lat0_status: err=%b lines=%0d expected 0/2", err_seen, ls_b); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 3) == 0) addr = 32'h1000 + ($urandom_range(0, 100000) << 5) + $urandom_range(0, 31);
      else addr = ($urandom_range(0, DEPTH / B - 1) << 5) + $urandom_range(0, 31);
      expect_line(addr);
      capture(addr, -1, 32'h0);
      exp_lines++;
      if (e_err) exp_errl++;
      for (int k = 0; k < B; k++) begin
        checks++; if (o_valid[L+1+k] !== 1'b1 || o_data[L+1+k] !== e_data[k] || o_err[L+1+k] !== e_err) begin errors++;
          $display("FAIL rand%0d_beat%0d addr=%h: valid=%b data=%h err=%b expected 1/%h/%b", it, k, addr, o_valid[L+1+k], o_data[L+1+k], o_err[L+1+k], e_data[k], e_err); end
      end
      checks++; if (o_ls[NC] !== 16'(exp_lines) || o_el[NC] !== 16'(exp_errl)) begin errors++;
        $display("FAIL rand%0d_counts: lines=%0d errl=%0d expected %0d/%0d", it, o_ls[NC], o_el[NC], exp_lines, exp_errl); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    bus_a.mem_cmd_valid = 1'b0; bus_a.mem_cmd_payload_address = '0;
    bus_b.mem_cmd_valid = 1'b0; bus_b.mem_cmd_payload_address = '0;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    preload();
    test_abort();
    test_basic();
    test_unaligned();
    test_oor();
    test_top_of_range();
    test_rbw();
    test_lat0_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
